// File: rtl/runner_ctrl_input_if.sv
// Button-side and control-side signals of the LED runner input conditioner.
// The master drives the raw buttons and the slave returns the conditioned controls.
interface runner_ctrl_input_if;
    logic       btn_en;
    logic       btn_speed;
    logic       btn_rst;
    logic       en;
    logic       speed;
    logic       rst_req;
    logic [2:0] press_pulse;

    modport master (
        output btn_en, btn_speed, btn_rst,
        input  en, speed, rst_req, press_pulse
    );

    modport slave (
        input  btn_en, btn_speed, btn_rst,
        output en, speed, rst_req, press_pulse
    );
endinterface

// File: rtl/runner_ctrl_input.sv
// Synchronises, debounces and one-pulses three pushbuttons into en/speed/rst_req for the runner.
// Optional CTRL_AUTO_PAUSE_EN: a reset press also pauses the runner and locks en until back in IDLE.
module runner_ctrl_input #(
    parameter int DB_SHIFT = 16,
    parameter int DB_DEPTH = 4,
    parameter int RST_HOLD = 8
) (
    input logic                clk,
    input logic                rst,
    runner_ctrl_input_if.slave bus
);
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        WAIT_REL
    } state_t;

    logic [DB_SHIFT-1:0] div;
    logic                sample_tick;
    logic [2:0]          raw;
    logic [2:0]          sync0;
    logic [2:0]          sync1;
    logic [2:0]          db;
    logic [2:0]          db_q;
    logic [2:0]          press;
    logic [DB_DEPTH-1:0] shreg [3];

    state_t              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic                en_q;
    logic                speed_q;
    logic                rst_req_q;

    assign raw         = {bus.btn_rst, bus.btn_speed, bus.btn_en};
    assign sample_tick = &div;
    assign press       = db & ~db_q;

    assign bus.en          = en_q;
    assign bus.speed       = speed_q;
    assign bus.rst_req     = rst_req_q;
    assign bus.press_pulse = press;

    // The debounced level only moves once DB_DEPTH consecutive samples agree; mixed history holds it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div   <= '0;
            sync0 <= '0;
            sync1 <= '0;
            db    <= '0;
            db_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                shreg[i] <= '0;
            end
        end else begin
            div   <= div + DB_SHIFT'(1);
            sync0 <= raw;
            sync1 <= sync0;
            db_q  <= db;
            for (int i = 0; i < 3; i++) begin
                if (sample_tick) begin
                    shreg[i] <= {shreg[i][DB_DEPTH-2:0], sync1[i]};
                end
                if (&shreg[i]) begin
                    db[i] <= 1'b1;
                end else if (~|shreg[i]) begin
                    db[i] <= 1'b0;
                end
            end
        end
    end

    // Reset press is accepted only from IDLE; its speed clear is written last so it beats a same-cycle toggle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            en_q      <= 1'b0;
            speed_q   <= 1'b0;
            rst_req_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (press[0]) begin
                        en_q <= ~en_q;
                    end
                    if (press[1]) begin
                        speed_q <= ~speed_q;
                    end
                    if (press[2]) begin
                        state     <= HOLD;
                        hold_cnt  <= HOLD_W'(RST_HOLD - 1);
                        rst_req_q <= 1'b1;
                        speed_q   <= 1'b0;
`ifdef CTRL_AUTO_PAUSE_EN
                        en_q      <= 1'b0;
`else
                        en_q      <= en_q ^ press[0];
`endif
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        rst_req_q <= 1'b0;
                        state     <= WAIT_REL;
                    end else begin
                        hold_cnt <= hold_cnt - HOLD_W'(1);
                    end
                end
                WAIT_REL: begin
`ifdef CTRL_AUTO_PAUSE_EN
                    en_q <= en_q;
`else
                    if (press[0]) begin
                        en_q <= ~en_q;
                    end
`endif
                    if (press[1]) begin
                        speed_q <= ~speed_q;
                    end
                    if (!db[2]) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
